// File: rtl/inst_fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_ctrl_if
// Brief    : Single-beat AXI-style read channel between fetch control and bus.
// Revision : 1.0
// ============================================================================
interface inst_fetch_ctrl_if;
  logic [31:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic        rvalid;
  logic        rready;

  modport master (
    output araddr, arvalid, rready,
    input  arready, rdata, rvalid
  );

  modport slave (
    input  araddr, arvalid, rready,
    output arready, rdata, rvalid
  );
endinterface
`default_nettype wire

// File: rtl/inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : inst_fetch_ctrl
// Brief    : PC owner and single-outstanding instruction fetch sequencer with
//            branch/flush redirect. FETCH_PERF_CNT_EN adds fetch/discard counters.
// Revision : 1.0
// ============================================================================
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hBFC00000,
  parameter int          ADEL_BIT = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  input  logic        next_pc_valid,
  inst_fetch_ctrl_if.master bus,
  output logic        valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic [31:0] pc_excepttype_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_cnt,
  output logic [31:0] discard_cnt
`endif
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ADDR    = 2'd1,
    S_DATA    = 2'd2,
    S_DISCARD = 2'd3
  } state_t;

  localparam logic [31:0] c_adel_mask = 32'h1 << ADEL_BIT;

  state_t      r_state, w_state_nxt;
  logic [31:0] r_pc;
  logic        r_arvalid, r_rready;
  logic        r_valid;
  logic [31:0] r_if_pc, r_if_inst, r_excepttype;
  logic        r_br_pend, r_br_slot;
  logic [31:0] r_br_target;
  logic        r_fl_pend;
  logic [31:0] r_fl_pc;
  logic        r_adel_hold;

  logic w_issue, w_adel, w_accept, w_complete, w_drop;
  logic w_unused_stall;

  assign w_unused_stall = ^stall[5:1];

  assign bus.araddr      = r_pc;
  assign bus.arvalid     = r_arvalid;
  assign bus.rready      = r_rready;
  assign valid           = r_valid;
  assign if_pc           = r_if_pc;
  assign if_inst         = r_if_inst;
  assign pc_excepttype_o = r_excepttype;

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_adel      = 1'b0;
    w_accept    = 1'b0;
    w_complete  = 1'b0;
    w_drop      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!flush) begin
          if (r_pc[1:0] != 2'b00) begin
            w_adel = !r_adel_hold;
          end else if (next_pc_valid && !stall[0]) begin
            w_issue     = 1'b1;
            w_state_nxt = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (bus.arready) begin
          w_accept    = 1'b1;
          w_state_nxt = (r_fl_pend || flush) ? S_DISCARD : S_DATA;
        end
      end
      S_DATA: begin
        if (bus.rvalid) begin
          // A flush coinciding with the response kills it outright.
          w_drop      = flush;
          w_complete  = !flush;
          w_state_nxt = S_IDLE;
        end else if (flush) begin
          w_state_nxt = S_DISCARD;
        end
      end
      S_DISCARD: begin
        if (bus.rvalid) begin
          w_drop      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_arvalid    <= 1'b0;
      r_rready     <= 1'b0;
      r_valid      <= 1'b0;
      r_if_pc      <= 32'h0;
      r_if_inst    <= 32'h0;
      r_excepttype <= 32'h0;
      r_br_pend    <= 1'b0;
      r_br_slot    <= 1'b0;
      r_br_target  <= 32'h0;
      r_fl_pend    <= 1'b0;
      r_fl_pc      <= 32'h0;
      r_adel_hold  <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      if (w_issue) r_arvalid <= 1'b1;
      if (w_accept) begin
        r_arvalid <= 1'b0;
        r_rready  <= 1'b1;
      end
      if (w_adel) begin
        r_valid      <= 1'b1;
        r_if_pc      <= r_pc;
        r_if_inst    <= 32'h0;
        r_excepttype <= c_adel_mask;
        r_adel_hold  <= 1'b1;
      end
      if (w_complete) begin
        r_rready     <= 1'b0;
        r_valid      <= 1'b1;
        r_if_pc      <= r_pc;
        r_if_inst    <= bus.rdata;
        r_excepttype <= 32'h0;
        // The first completion after a branch is the delay slot; the next one takes the target.
        if (r_br_pend && r_br_slot) begin
          r_pc      <= r_br_target;
          r_br_pend <= 1'b0;
        end else begin
          r_pc <= r_pc + 32'd4;
          if (r_br_pend) r_br_slot <= 1'b1;
        end
      end
      if (w_drop) begin
        r_rready    <= 1'b0;
        r_pc        <= flush ? new_pc : r_fl_pc;
        r_fl_pend   <= 1'b0;
        r_adel_hold <= 1'b0;
      end
      if (flush) begin
        r_br_pend <= 1'b0;
        if (r_state == S_IDLE) begin
          r_pc        <= new_pc;
          r_adel_hold <= 1'b0;
        end else if (!w_drop) begin
          r_fl_pend <= 1'b1;
          r_fl_pc   <= new_pc;
        end
      end else if (branch_flag && !r_fl_pend && r_state != S_DISCARD) begin
        r_br_pend   <= 1'b1;
        r_br_target <= branch_target;
        r_br_slot   <= (r_state == S_IDLE) || w_complete;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt, r_discard_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt   <= 32'h0;
      r_discard_cnt <= 32'h0;
    end else begin
      if (w_complete || w_adel) r_fetch_cnt   <= r_fetch_cnt + 32'd1;
      if (w_drop)               r_discard_cnt <= r_discard_cnt + 32'd1;
    end
  end

  assign fetch_cnt   = r_fetch_cnt;
  assign discard_cnt = r_discard_cnt;
`endif

endmodule
`default_nettype wire

// File: tb/tb_inst_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_inst_fetch_ctrl
// Brief    : Directed scoreboard bench for inst_fetch_ctrl with a bus slave model.
// Revision : 1.0
// ============================================================================
module tb_inst_fetch_ctrl;
  logic        clk;
  logic        rst;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        next_pc_valid;
  logic        valid;
  logic [31:0] if_pc, if_inst, pc_excepttype_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt, discard_cnt;
`endif

  inst_fetch_ctrl_if bus ();

  inst_fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .new_pc          (new_pc),
    .branch_flag     (branch_flag),
    .branch_target   (branch_target),
    .next_pc_valid   (next_pc_valid),
    .bus             (bus),
    .valid           (valid),
    .if_pc           (if_pc),
    .if_inst         (if_inst),
    .pc_excepttype_o (pc_excepttype_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt       (fetch_cnt),
    .discard_cnt     (discard_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int n_valid = 0;
  logic [95:0] exp_q[$];
  logic [31:0] addr_q[$];
  logic [31:0] slow_addr;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a == 32'hBFC00000) ? 32'h24010001 : (a ^ 32'h5A5AA5A5);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_fetch(input logic [31:0] a);
    addr_q.push_back(a);
    exp_q.push_back({a, mem(a), 32'h0});
  endtask

  task automatic wait_addr(input logic [31:0] a);
    logic ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clk); #2;
      if (bus.arvalid && bus.araddr == a) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wait_araddr", {31'b0, ok}, 32'd1);
  endtask

  task automatic wait_drain();
    logic ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0 && addr_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk("drain", {31'b0, ok}, 32'd1);
  endtask

  // Bus slave: arready one cycle after arvalid (slow_addr waits longer), rvalid one cycle after rready.
  initial begin
    logic        pend;
    logic [31:0] cap, rd_addr;
    int          ar_cnt;
    pend = 1'b0; cap = 32'h0; rd_addr = 32'h0; ar_cnt = 0;
    bus.arready = 1'b0; bus.rvalid = 1'b0; bus.rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (rst) begin
        bus.arready = 1'b0; bus.rvalid = 1'b0; pend = 1'b0; ar_cnt = 0;
      end else begin
        if (bus.arready) begin
          bus.arready = 1'b0;
          pend = 1'b1;
          rd_addr = cap;
        end else if (bus.arvalid) begin
          ar_cnt++;
          if (ar_cnt > ((bus.araddr == slow_addr) ? 5 : 0)) begin
            bus.arready = 1'b1;
            cap = bus.araddr;
            ar_cnt = 0;
          end
        end
        if (bus.rvalid) begin
          bus.rvalid = 1'b0;
        end else if (pend && bus.rready) begin
          bus.rvalid = 1'b1;
          bus.rdata  = mem(rd_addr);
          pend = 1'b0;
        end
      end
    end
  end

  // Monitor: scoreboard pops on valid and on each new read request.
  initial begin
    logic        prev_arvalid;
    logic [31:0] prev_araddr;
    logic [95:0] e;
    prev_arvalid = 1'b0; prev_araddr = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!rst) begin
        if (valid) begin
          n_valid++;
          chk("valid_expected", {31'b0, exp_q.size() != 0}, 32'd1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("if_pc", if_pc, e[95:64]);
            chk("if_inst", if_inst, e[63:32]);
            chk("excepttype", pc_excepttype_o, e[31:0]);
          end
        end
        if (bus.arvalid && !prev_arvalid) begin
          chk("ar_expected", {31'b0, addr_q.size() != 0}, 32'd1);
          chk("ar_not_stalled", {31'b0, stall[0]}, 32'd0);
          if (addr_q.size() != 0) chk("araddr", bus.araddr, addr_q.pop_front());
        end
        if (bus.arvalid && prev_arvalid) chk("araddr_stable", bus.araddr, prev_araddr);
        if (!bus.arvalid && prev_arvalid) chk("arvalid_held_to_arready", {31'b0, bus.arready}, 32'd1);
      end
      prev_arvalid = bus.arvalid;
      prev_araddr  = bus.araddr;
    end
  end

  initial begin
    int nv;
    rst = 1'b1; stall = 6'b0; flush = 1'b0; new_pc = 32'h0;
    branch_flag = 1'b0; branch_target = 32'h0; next_pc_valid = 1'b1;
    slow_addr = 32'hBFC00384;
    repeat (3) @(negedge clk);
    chk("rst_arvalid", {31'b0, bus.arvalid}, 32'd0);
    chk("rst_rready", {31'b0, bus.rready}, 32'd0);
    chk("rst_valid", {31'b0, valid}, 32'd0);
    chk("rst_if_pc", if_pc, 32'h0);
    chk("rst_if_inst", if_inst, 32'h0);
    chk("rst_excepttype", pc_excepttype_o, 32'h0);
    chk("rst_araddr", bus.araddr, 32'hBFC00000);

    // Sequential fetch, branch with delay slot, flush in DATA, flush during slow ADDR.
    push_fetch(32'hBFC00000);
    push_fetch(32'hBFC00004);
    push_fetch(32'hBFC00008);
    push_fetch(32'hBFC0000C);
    push_fetch(32'hBFC00100);
    addr_q.push_back(32'hBFC00104);
    push_fetch(32'hBFC00380);
    addr_q.push_back(32'hBFC00384);
    push_fetch(32'hBFC00400);
    rst = 1'b0;

    wait_addr(32'hBFC00008);
    @(negedge clk); branch_flag = 1'b1; branch_target = 32'hBFC00100;
    @(negedge clk); branch_flag = 1'b0;

    wait_addr(32'hBFC00104);
    @(negedge clk);
    @(negedge clk); flush = 1'b1; new_pc = 32'hBFC00380;
    @(negedge clk); flush = 1'b0;

    wait_addr(32'hBFC00384);
    @(negedge clk);
    @(negedge clk); flush = 1'b1; new_pc = 32'hBFC00400;
    @(negedge clk); flush = 1'b0;

    wait_addr(32'hBFC00400);
    @(negedge clk); next_pc_valid = 1'b0;
    wait_drain();

    // Misaligned redirect: exception pulse, no bus access, then hold.
    exp_q.push_back({32'hBFC00382, 32'h0, 32'h00004000});
    @(negedge clk); flush = 1'b1; new_pc = 32'hBFC00382; next_pc_valid = 1'b1;
    @(negedge clk); flush = 1'b0;
    repeat (10) @(negedge clk);
    wait_drain();

    // Stall during an in-flight fetch.
    push_fetch(32'hBFC00500);
    push_fetch(32'hBFC00504);
    @(negedge clk); flush = 1'b1; new_pc = 32'hBFC00500;
    @(negedge clk); flush = 1'b0;
    wait_addr(32'hBFC00500);
    nv = n_valid;
    @(negedge clk); stall = 6'b000001;
    repeat (8) @(negedge clk);
    chk("stall_valid_emitted", n_valid, nv + 1);
    stall = 6'b0;
    wait_addr(32'hBFC00504);
    @(negedge clk); next_pc_valid = 1'b0;
    wait_drain();

    chk("exp_q_empty", exp_q.size(), 32'd0);
    chk("addr_q_empty", addr_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
